// File: rtl/stream_checker_pkg.sv
// Shared types and helpers for the stream_checker block: compare modes,
// pass/fail statistics record and a saturating adder.
package checker_pkg;

  typedef enum logic [1:0] {
    CMP_EXACT     = 2'd0,
    CMP_MASKED    = 2'd1,
    CMP_TOLERANCE = 2'd2
  } cmp_mode_e;

  typedef struct packed {
    int unsigned pass;
    int unsigned fail;
  } test_stats;

  // Adds two unsigned values and clamps the result to 2^w-1 (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/stream_checker_if.sv
// Expected/actual stream bundle. exp_* is a valid/ready push: a word transfers
// on a cycle where exp_valid and exp_ready are both high. act_* is a strobe with
// no backpressure: every cycle with act_valid high presents one actual word.
interface stream_checker_if #(
  parameter int NCHAN  = 4,
  parameter int DATA_W = 32
);
  logic [NCHAN-1:0]        exp_valid;
  logic [NCHAN-1:0]        exp_ready;
  logic [NCHAN*DATA_W-1:0] exp_data;
  logic [NCHAN-1:0]        act_valid;
  logic [NCHAN*DATA_W-1:0] act_data;

  modport master (
    output exp_valid, exp_data, act_valid, act_data,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_data, act_valid, act_data,
    output exp_ready
  );
endinterface

// File: rtl/stream_checker_fifo.sv
// Per-channel expected-word FIFO. Head word is visible combinationally on rdata;
// push while full and pop while empty are ignored.
module checker_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/stream_checker.sv
// Multi-channel in-order result checker: per-channel expected FIFOs, a two-stage
// compare pipeline, saturating pass/fail counters, first-mismatch capture and sticky flags.
module stream_checker
  import checker_pkg::*;
#(
  parameter int NCHAN  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32,
  localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  cmp_mode_e               mode,
  input  logic [DATA_W-1:0]       mask,
  input  logic [DATA_W-1:0]       tol,
  stream_checker_if.slave         bus,
  output logic [NCHAN*CNT_W-1:0]  ch_pass_cnt,
  output logic [NCHAN*CNT_W-1:0]  ch_fail_cnt,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        fail_cnt,
  output logic                    first_fail_vld,
  output logic [CW-1:0]           first_fail_ch,
  output logic [CNT_W-1:0]        first_fail_idx,
  output logic [DATA_W-1:0]       first_fail_exp,
  output logic [DATA_W-1:0]       first_fail_act,
  output logic [NCHAN-1:0]        underflow,
  output logic [NCHAN-1:0]        overflow,
  output logic                    idle
);
  localparam int OW = $clog2(DEPTH) + 1;

  wire  [NCHAN-1:0]  fifo_full;
  wire  [NCHAN-1:0]  fifo_empty;
  wire  [DATA_W-1:0] fifo_head [NCHAN];
  wire  [OW-1:0]     fifo_cnt  [NCHAN];

  // Stage 1 registers
  logic [NCHAN-1:0]  s1_vld;
  logic [DATA_W-1:0] s1_exp [NCHAN];
  logic [DATA_W-1:0] s1_act [NCHAN];
  cmp_mode_e         s1_mode;
  logic [DATA_W-1:0] s1_mask;
  logic [DATA_W-1:0] s1_tol;

  // Counter and capture state
  logic [CNT_W-1:0]  ch_pass_q [NCHAN];
  logic [CNT_W-1:0]  ch_fail_q [NCHAN];
  logic [CNT_W-1:0]  ch_idx_q  [NCHAN];

  // Stage 2 combinational results
  logic [NCHAN-1:0]  pass_v;
  logic [NCHAN-1:0]  fail_v;
  logic [63:0]       pass_inc;
  logic [63:0]       fail_inc;
  logic              ff_hit;
  logic [CW-1:0]     ff_sel;
  logic [CNT_W-1:0]  ff_idx;
  logic [DATA_W-1:0] ff_exp;
  logic [DATA_W-1:0] ff_act;

  genvar gc;
  generate
    for (gc = 0; gc < NCHAN; gc++) begin : g_fifo
      checker_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (bus.exp_valid[gc]),
        .pop   (bus.act_valid[gc]),
        .wdata (bus.exp_data[gc*DATA_W +: DATA_W]),
        .rdata (fifo_head[gc]),
        .full  (fifo_full[gc]),
        .empty (fifo_empty[gc]),
        .count (fifo_cnt[gc])
      );
    end
  endgenerate

  // Space is judged from registered occupancy only; a same-cycle pop does not help.
  assign bus.exp_ready = ~fifo_full;

  // TOLERANCE treats both words as signed and subtracts at DATA_W+1 bits.
  function automatic logic is_match(input logic [DATA_W-1:0] e,
                                    input logic [DATA_W-1:0] a,
                                    input cmp_mode_e         m,
                                    input logic [DATA_W-1:0] mk,
                                    input logic [DATA_W-1:0] tl);
    logic signed [DATA_W:0] diff;
    logic [DATA_W:0]        mag;
    diff = $signed({e[DATA_W-1], e}) - $signed({a[DATA_W-1], a});
    mag  = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    case (m)
      CMP_MASKED:    return ((e ^ a) & mk) == '0;
      CMP_TOLERANCE: return mag <= {1'b0, tl};
      default:       return e == a;
    endcase
  endfunction

  always_comb begin
    pass_v   = '0;
    fail_v   = '0;
    pass_inc = '0;
    fail_inc = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (s1_vld[c]) begin
        if (is_match(s1_exp[c], s1_act[c], s1_mode, s1_mask, s1_tol)) pass_v[c] = 1'b1;
        else                                                          fail_v[c] = 1'b1;
      end
      pass_inc = pass_inc + 64'(pass_v[c]);
      fail_inc = fail_inc + 64'(fail_v[c]);
    end
  end

  // Descending scan so the lowest failing channel is the one left selected.
  always_comb begin
    ff_hit = 1'b0;
    ff_sel = '0;
    ff_idx = '0;
    ff_exp = '0;
    ff_act = '0;
    for (int c = NCHAN - 1; c >= 0; c--) begin
      if (fail_v[c]) begin
        ff_hit = 1'b1;
        ff_sel = CW'(c);
        ff_idx = ch_idx_q[c];
        ff_exp = s1_exp[c];
        ff_act = s1_act[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld         <= '0;
      s1_mode        <= CMP_EXACT;
      s1_mask        <= '0;
      s1_tol         <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_ch  <= '0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_act <= '0;
      underflow      <= '0;
      overflow       <= '0;
      for (int c = 0; c < NCHAN; c++) begin
        s1_exp[c]    <= '0;
        s1_act[c]    <= '0;
        ch_pass_q[c] <= '0;
        ch_fail_q[c] <= '0;
        ch_idx_q[c]  <= '0;
      end
    end else if (clr) begin
      s1_vld         <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_ch  <= '0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_act <= '0;
      underflow      <= '0;
      overflow       <= '0;
      for (int c = 0; c < NCHAN; c++) begin
        ch_pass_q[c] <= '0;
        ch_fail_q[c] <= '0;
        ch_idx_q[c]  <= '0;
      end
    end else begin
      s1_vld    <= bus.act_valid & ~fifo_empty;
      s1_mode   <= mode;
      s1_mask   <= mask;
      s1_tol    <= tol;
      underflow <= underflow | (bus.act_valid & fifo_empty);
      overflow  <= overflow  | (bus.exp_valid & fifo_full);
      pass_cnt  <= CNT_W'(sat_add(64'(pass_cnt), pass_inc, CNT_W));
      fail_cnt  <= CNT_W'(sat_add(64'(fail_cnt), fail_inc, CNT_W));
      for (int c = 0; c < NCHAN; c++) begin
        s1_exp[c]    <= fifo_head[c];
        s1_act[c]    <= bus.act_data[c*DATA_W +: DATA_W];
        ch_pass_q[c] <= CNT_W'(sat_add(64'(ch_pass_q[c]), 64'(pass_v[c]), CNT_W));
        ch_fail_q[c] <= CNT_W'(sat_add(64'(ch_fail_q[c]), 64'(fail_v[c]), CNT_W));
        ch_idx_q[c]  <= CNT_W'(sat_add(64'(ch_idx_q[c]), 64'(s1_vld[c]), CNT_W));
      end
      if (!first_fail_vld && ff_hit) begin
        first_fail_vld <= 1'b1;
        first_fail_ch  <= ff_sel;
        first_fail_idx <= ff_idx;
        first_fail_exp <= ff_exp;
        first_fail_act <= ff_act;
      end
    end
  end

  always_comb begin
    ch_pass_cnt = '0;
    ch_fail_cnt = '0;
    idle        = (s1_vld == '0);
    for (int c = 0; c < NCHAN; c++) begin
      ch_pass_cnt[c*CNT_W +: CNT_W] = ch_pass_q[c];
      ch_fail_cnt[c*CNT_W +: CNT_W] = ch_fail_q[c];
      if (fifo_cnt[c] != '0) idle = 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: a 4-channel 32-bit instance (DEPTH=4, CNT_W=4)
// and a 1-channel 8-bit instance for signed tolerance compares.
module tb_stream_checker;
  import checker_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  stream_checker_if #(.NCHAN(4), .DATA_W(32)) bus ();
  cmp_mode_e   mode;
  logic [31:0] mask, tol;
  logic [15:0] ch_pass_cnt, ch_fail_cnt;
  logic [3:0]  pass_cnt, fail_cnt, first_fail_idx;
  logic        first_fail_vld, idle;
  logic [1:0]  first_fail_ch;
  logic [31:0] first_fail_exp, first_fail_act;
  logic [3:0]  underflow, overflow;

  stream_checker #(.NCHAN(4), .DATA_W(32), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .mask(mask), .tol(tol),
    .bus(bus.slave),
    .ch_pass_cnt(ch_pass_cnt), .ch_fail_cnt(ch_fail_cnt),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_ch(first_fail_ch),
    .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp),
    .first_fail_act(first_fail_act),
    .underflow(underflow), .overflow(overflow), .idle(idle)
  );

  // ---------------- 8-bit instance ----------------
  stream_checker_if #(.NCHAN(1), .DATA_W(8)) bus8 ();
  cmp_mode_e  mode8;
  logic [7:0] mask8, tol8;
  logic [7:0] ch_pass8, ch_fail8, pass8, fail8, ff_idx8;
  logic       ff_vld8, idle8;
  logic [0:0] ff_ch8;
  logic [7:0] ff_exp8, ff_act8;
  logic [0:0] uf8, of8;

  stream_checker #(.NCHAN(1), .DATA_W(8), .DEPTH(4), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode8), .mask(mask8), .tol(tol8),
    .bus(bus8.slave),
    .ch_pass_cnt(ch_pass8), .ch_fail_cnt(ch_fail8),
    .pass_cnt(pass8), .fail_cnt(fail8),
    .first_fail_vld(ff_vld8), .first_fail_ch(ff_ch8),
    .first_fail_idx(ff_idx8), .first_fail_exp(ff_exp8),
    .first_fail_act(ff_act8),
    .underflow(uf8), .overflow(of8), .idle(idle8)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] ev, input logic [127:0] ed,
                     input logic [3:0] av, input logic [127:0] ad);
    bus.exp_valid = ev;
    bus.exp_data  = ed;
    bus.act_valid = av;
    bus.act_data  = ad;
    tick();
    bus.exp_valid = '0;
    bus.act_valid = '0;
  endtask

  task automatic push(input int ch, input logic [31:0] d);
    logic [3:0]   v;
    logic [127:0] w;
    v = '0;
    w = '0;
    v[ch] = 1'b1;
    w[ch*32 +: 32] = d;
    cyc(v, w, 4'b0, 128'b0);
  endtask

  task automatic act(input int ch, input logic [31:0] d);
    logic [3:0]   v;
    logic [127:0] w;
    v = '0;
    w = '0;
    v[ch] = 1'b1;
    w[ch*32 +: 32] = d;
    cyc(4'b0, 128'b0, v, w);
  endtask

  task automatic push8(input logic [7:0] d);
    bus8.exp_valid = 1'b1;
    bus8.exp_data  = d;
    tick();
    bus8.exp_valid = 1'b0;
  endtask

  task automatic act8(input logic [7:0] d);
    bus8.act_valid = 1'b1;
    bus8.act_data  = d;
    tick();
    bus8.act_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    mode  = CMP_EXACT;
    mask  = '0;
    tol   = '0;
    bus.exp_valid = '0; bus.exp_data = '0; bus.act_valid = '0; bus.act_data = '0;
    mode8 = CMP_TOLERANCE;
    mask8 = '0;
    tol8  = 8'd2;
    bus8.exp_valid = '0; bus8.exp_data = '0; bus8.act_valid = '0; bus8.act_data = '0;
    repeat (3) tick();

    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_exp_ready", bus.exp_ready, 4'hF);
    check("rst_idle", idle, 1);
    check("rst_ff_vld", first_fail_vld, 0);
    check("rst_flags", {underflow, overflow}, 0);
    rst_n = 1'b1;
    tick();

    // Signed tolerance on 8 bits: 0x81 is -127, far from +127 despite the raw wrap.
    push8(8'h7F); push8(8'h7F); push8(8'hFF);
    act8(8'h81); act8(8'h7D); act8(8'h01);
    tick();
    check("tol_pass", pass8, 2);
    check("tol_fail", fail8, 1);
    check("tol_ff_idx", ff_idx8, 0);
    check("tol_ff_act", ff_act8, 8'h81);
    check("tol_ff_exp", ff_exp8, 8'h7F);
    check("tol_idle", idle8, 1);

    // EXACT: four matching words on ch0
    for (int i = 0; i < 4; i++) push(0, 32'h10 + i);
    check("exact_full_ready", bus.exp_ready, 4'b1110);
    check("exact_busy", idle, 0);
    for (int i = 0; i < 4; i++) act(0, 32'h10 + i);
    tick();
    check("exact_ch0_pass", ch_pass_cnt[3:0], 4);
    check("exact_pass", pass_cnt, 4);
    check("exact_fail", fail_cnt, 0);
    check("exact_idle", idle, 1);

    // MASKED: only the upper half is compared
    clr_pulse();
    check("clr_pass", pass_cnt, 0);
    mode = CMP_MASKED;
    mask = 32'hFFFF_0000;
    push(0, 32'h1234_AAAA); push(0, 32'h1234_AAAA);
    act(0, 32'h1234_5555); act(0, 32'h1235_AAAA);
    tick();
    check("mask_pass", pass_cnt, 1);
    check("mask_fail", fail_cnt, 1);
    check("mask_ff_vld", first_fail_vld, 1);
    check("mask_ff_idx", first_fail_idx, 1);
    check("mask_ff_exp", first_fail_exp, 32'h1234_AAAA);
    check("mask_ff_act", first_fail_act, 32'h1235_AAAA);

    // Simultaneous failures on ch1 and ch3, then a later ch0 failure
    clr_pulse();
    mode = CMP_EXACT;
    cyc(4'b1011, {32'hA3, 32'h0, 32'hA1, 32'hB0}, 4'b0, 128'b0);
    cyc(4'b0, 128'b0, 4'b1010, {32'hEE, 32'h0, 32'hFF, 32'h0});
    tick();
    check("dual_fail_cnt", fail_cnt, 2);
    check("dual_ch3_fail", ch_fail_cnt[15:12], 1);
    check("dual_ff_ch", first_fail_ch, 1);
    check("dual_ff_act", first_fail_act, 32'hFF);
    check("dual_ff_idx", first_fail_idx, 0);
    act(0, 32'hB1);
    tick();
    check("late_fail_cnt", fail_cnt, 3);
    check("late_ch0_fail", ch_fail_cnt[3:0], 1);
    check("late_ff_ch", first_fail_ch, 1);
    check("late_ff_exp", first_fail_exp, 32'hA1);

    // Overflow on ch2, underflow on ch1, dropped fifth word
    clr_pulse();
    for (int i = 0; i < 4; i++) push(2, 32'h20 + i);
    check("ovf_ready", bus.exp_ready, 4'b1011);
    check("ovf_none_yet", overflow, 0);
    push(2, 32'h24);
    check("ovf_flag", overflow, 4'b0100);
    act(1, 32'h99);
    check("unf_flag", underflow, 4'b0010);
    for (int i = 0; i < 4; i++) act(2, 32'h20 + i);
    act(2, 32'h24);
    check("unf_dropped_word", underflow, 4'b0110);
    tick();
    check("ovf_pass", pass_cnt, 4);
    check("ovf_fail", fail_cnt, 0);
    check("ovf_ch2_pass", ch_pass_cnt[11:8], 4);
    check("unf_ch1_pass", ch_pass_cnt[7:4], 0);
    check("ovf_idle", idle, 1);

    // Saturation at 15 with CNT_W=4
    clr_pulse();
    check("clr_flags", {underflow, overflow, 3'b0, first_fail_vld}, 0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) push(0, 32'h100 + r*4 + i);
      for (int i = 0; i < 4; i++) act(0, 32'h100 + r*4 + i);
    end
    tick();
    check("sat_pass", pass_cnt, 15);
    check("sat_ch0_pass", ch_pass_cnt[3:0], 15);
    check("sat_fail", fail_cnt, 0);

    // clr while a compare sits in stage 1 and another word waits in the FIFO
    push(0, 32'h1); push(0, 32'h2);
    act(0, 32'h1);
    clr = 1'b1;
    act(0, 32'h2);
    clr = 1'b0;
    check("clr_mid_pass", pass_cnt, 0);
    check("clr_mid_idle", idle, 1);
    check("clr_mid_ready", bus.exp_ready, 4'hF);
    tick();
    check("clr_mid_after", pass_cnt, 0);

    // Reset mid-stream with a failing compare in flight
    push(0, 32'h5); push(0, 32'h6);
    act(0, 32'h7);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_fail", fail_cnt, 0);
    check("rst_mid_ff_vld", first_fail_vld, 0);
    check("rst_mid_idle", idle, 1);
    check("rst_mid_ready", bus.exp_ready, 4'hF);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("rst_after_fail", fail_cnt, 0);
    check("rst_after_pass", pass_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_checker.md
# stream_checker

Synthesizable multi-channel result checker for MVU testbenches and on-chip self-test. Each channel buffers expected words in a per-channel FIFO and compares them in order against actual words from the DUT output. It keeps saturating per-channel and aggregate pass/fail counts, records the first mismatch, and flags sticky protocol errors. Successor to the software-only pass/fail tally: the counting is moved into hardware, generalised to N channels, selectable compare modes and a bounded expected-value buffer.

## Interface
- `NCHAN`, 4: number of independent channels (1..16).
- `DATA_W`, 32: width of expected/actual words.
- `DEPTH`, 16: expected-FIFO depth per channel (power of two, ≥2).
- `CNT_W`, 32: counter width (matches `int unsigned` stats).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of FIFOs, counters, flags and capture.
- `mode`  in  2  `cmp_mode_e`: EXACT, MASKED, TOLERANCE. Sampled on each compare.
- `mask`  in  DATA_W  bit mask used in MASKED mode (1 = compare bit).
- `tol`  in  DATA_W  unsigned tolerance used in TOLERANCE mode.
- `exp_valid`  in  NCHAN  expected word valid, per channel.
- `exp_ready`  out  NCHAN  expected FIFO not full, per channel.
- `exp_data`  in  NCHAN*DATA_W  expected words; channel c is bits [c*DATA_W +: DATA_W].
- `act_valid`  in  NCHAN  actual word strobe. No backpressure.
- `act_data`  in  NCHAN*DATA_W  actual words.
- `ch_pass_cnt`, `ch_fail_cnt`  out  NCHAN*CNT_W  per-channel counters.
- `pass_cnt`, `fail_cnt`  out  CNT_W  aggregate counters.
- `first_fail_vld`  out  1  a mismatch has been captured.
- `first_fail_ch`  out  $clog2(NCHAN) (min 1)  channel of the first mismatch.
- `first_fail_idx`  out  CNT_W  per-channel compare index of the first mismatch (0-based).
- `first_fail_exp`, `first_fail_act`  out  DATA_W  captured expected and actual words.
- `underflow`, `overflow`  out  NCHAN  sticky protocol-error flags.
- `idle`  out  1  all FIFOs empty and no compare in flight.

## Operation
- Push: `exp_valid[c] && exp_ready[c]` writes `exp_data[c]` into FIFO c.
- `exp_ready[c] = !full[c]`. It is derived from the registered occupancy only; a pop in the same cycle does not free space for a push.
- `exp_valid[c]` asserted while FIFO c is full: the word is dropped and `overflow[c]` is set.
- Compare: on `act_valid[c]` with FIFO c non-empty, the head is popped and compared.
  - EXACT: match when `exp == act`.
  - MASKED: match when `(exp^act)&mask == 0`.
  - TOLERANCE: operands are signed two's complement. Match when |exp−act| ≤ `tol`. Compute the difference at DATA_W+1 bits so it cannot overflow.
- `act_valid[c]` with FIFO c empty: no compare takes place, no counter changes, and `underflow[c]` is set. There is no bypass from a same-cycle push.
- Counters saturate at 2^CNT_W−1.
- The aggregate counter adds the popcount of this cycle's per-channel results. Add as an unsigned sum, then saturate.
- First-fail capture: latched only while `first_fail_vld==0`. If several channels fail in the same cycle, the lowest channel index wins.
- `clr` has priority over every same-cycle event.

## Timing
- Reset and `clr` values:
  - all counters 0, flags 0, capture fields 0, `first_fail_vld` 0;
  - FIFOs empty, so `exp_ready` is all-ones and `idle` is 1.
- Compare pipeline has 2 stages:
  - Stage 1 (the `act_valid` cycle): pop and register {exp, act, mode, mask, tol}.
  - Stage 2: evaluate the match and update counters and capture on the next edge.
- Counters therefore reflect a compare 2 cycles after `act_valid`.
- `underflow` and `overflow` set 1 cycle after the offending strobe.
- `idle` falls in the cycle after a push or act strobe. It returns to 1 only after stage 2 drains.
- Throughput: one push and one compare per channel per cycle.
- Reset asserted mid-operation clears everything immediately, including in-flight stage registers. Nothing is counted for them.
- A `clr` in the same cycle as stage 2 drops that result.

## Structure
- Shared package `checker_pkg`:
  - `cmp_mode_e` enum;
  - the `test_stats` struct (pass/fail `int unsigned`);
  - a `sat_add` function.
- Sub-module `checker_fifo`: synchronous FIFO with `DATA_W` and `DEPTH` parameters, full/empty outputs and an occupancy count. Instantiated NCHAN times in a generate loop.
- Top level holds the compare pipeline, counters, capture logic and flags.

## Test plan
- EXACT, NCHAN=4: push 0x10..0x13 on ch0 and strobe the same four values as actuals → `ch_pass_cnt[0]=4`, `pass_cnt=4`, `fail_cnt=0`, `idle=1` after 2 cycles.
- MASKED, mask=0xFFFF0000: exp 0x1234_AAAA, act 0x1234_5555 → pass. Then act 0x1235_AAAA → fail, `first_fail_idx=1`, `first_fail_exp=0x1234_AAAA`.
- TOLERANCE, tol=2, DATA_W=8: exp 0x7F against acts 0x81 and 0x7D (exp 0x7F pushed twice) → 0x81 (−127) fails, 0x7D passes. The signed-wrap case must not pass.
- Channels 1 and 3 mismatch in the same cycle → `first_fail_ch=1`, `fail_cnt` +2. A later ch0 failure leaves the capture unchanged.
- DEPTH=4: push 5 words on ch2 with no pops → `exp_ready[2]=0` after 4, `overflow[2]=1`. Then act on empty ch1 → `underflow[1]=1` and counters unchanged.
- CNT_W=4: 20 passing compares → `pass_cnt` holds at 15. Then `clr` mid-stream, followed by `rst_n` low mid-stream → all outputs return to their reset values.
